// File: rtl/ctrl_delay_pkg.sv
// Shared definitions for the control-signal delay line.
package ctrl_delay_pkg;

  localparam int CTRL_DELAY_DEPTH_DEFAULT = 2;
  localparam int CTRL_DELAY_MAX_DEPTH     = 16;

  // Per-edge control pair applied identically to every stage.
  typedef struct packed {
    logic stall;
    logic flush;
  } ctrl_delay_ctl_t;

endpackage

// File: rtl/ctrl_delay_stage.sv
// One WIDTH-bit delay stage with reset > flush > stall > load priority.
module ctrl_delay_stage
  import ctrl_delay_pkg::*;
#(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  ctrl_delay_ctl_t  ctl,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= RESET_VAL;
    end else if (ctl.flush) begin
      q <= RESET_VAL;
    end else if (!ctl.stall) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ctrl_delay_line.sv
// DEPTH-stage shift register carrying a WIDTH-bit control vector.
// Define CTRL_DELAY_TAPS_EN to expose every stage on the taps port.
module ctrl_delay_line
  import ctrl_delay_pkg::*;
#(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = CTRL_DELAY_DEPTH_DEFAULT,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             stall,
  input  logic             flush,
  output logic [WIDTH-1:0] out
`ifdef CTRL_DELAY_TAPS_EN
  ,
  output logic [DEPTH*WIDTH-1:0] taps
`endif
);

  if (DEPTH < 1 || DEPTH > CTRL_DELAY_MAX_DEPTH) begin : g_bad_depth
    $error("ctrl_delay_line: DEPTH must be in 1..16");
  end

  ctrl_delay_ctl_t  ctl;
  logic [WIDTH-1:0] stage_q [DEPTH];

  assign ctl.stall = stall;
  assign ctl.flush = flush;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    logic [WIDTH-1:0] d;

    if (gi == 0) begin : g_head
      assign d = in;
    end else begin : g_tail
      assign d = stage_q[gi-1];
    end

    ctrl_delay_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk   (clk),
      .reset (reset),
      .ctl   (ctl),
      .d     (d),
      .q     (stage_q[gi])
    );

`ifdef CTRL_DELAY_TAPS_EN
    assign taps[gi*WIDTH +: WIDTH] = stage_q[gi];
`endif
  end

  // Output is the last register directly; no path from in to out.
  assign out = stage_q[DEPTH-1];

endmodule

// File: tb/tb_ctrl_delay_line.sv
// Self-checking bench: three delay-line configurations against a queue model.
module tb_ctrl_delay_line;

  logic       clk = 1'b0;
  logic       reset, stall, flush;
  logic       in2;
  logic [7:0] in3;
  logic [3:0] in1;
  logic       out2;
  logic [7:0] out3;
  logic [3:0] out1;
`ifdef CTRL_DELAY_TAPS_EN
  logic [1:0]  taps2;
  logic [23:0] taps3;
  logic [3:0]  taps1;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: each pipeline is a queue, index 0 = newest stage.
  logic       q2[$];
  logic [7:0] q3[$];
  logic [3:0] q1[$];

  always #5 clk = ~clk;

  ctrl_delay_line #(.WIDTH(1), .DEPTH(2)) dut2 (
    .clk(clk), .reset(reset), .in(in2), .stall(stall), .flush(flush), .out(out2)
`ifdef CTRL_DELAY_TAPS_EN
    , .taps(taps2)
`endif
  );

  ctrl_delay_line #(.WIDTH(8), .DEPTH(3)) dut3 (
    .clk(clk), .reset(reset), .in(in3), .stall(stall), .flush(flush), .out(out3)
`ifdef CTRL_DELAY_TAPS_EN
    , .taps(taps3)
`endif
  );

  ctrl_delay_line #(.WIDTH(4), .DEPTH(1)) dut1 (
    .clk(clk), .reset(reset), .in(in1), .stall(stall), .flush(flush), .out(out1)
`ifdef CTRL_DELAY_TAPS_EN
    , .taps(taps1)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic f, input logic s);
    if (r || f) begin
      foreach (q2[i]) q2[i] = 1'b0;
      foreach (q3[i]) q3[i] = 8'h00;
      foreach (q1[i]) q1[i] = 4'h0;
    end else if (!s) begin
      q2.push_front(in2); void'(q2.pop_back());
      q3.push_front(in3); void'(q3.pop_back());
      q1.push_front(in1); void'(q1.pop_back());
    end
  endtask

  task automatic step(input logic r, input logic f, input logic s,
                      input logic i2, input logic [7:0] i3, input logic [3:0] i1);
    @(negedge clk);
    reset = r; flush = f; stall = s; in2 = i2; in3 = i3; in1 = i1;
    @(posedge clk);
    model_edge(r, f, s);
    #1;
    check("out_d2", {31'b0, out2}, {31'b0, q2[1]});
    check("out_d3", {24'b0, out3}, {24'b0, q3[2]});
    check("out_d1", {28'b0, out1}, {28'b0, q1[0]});
`ifdef CTRL_DELAY_TAPS_EN
    check("taps_d2", {30'b0, taps2}, {30'b0, q2[1], q2[0]});
    check("taps_d3", {8'b0, taps3}, {8'b0, q3[2], q3[1], q3[0]});
    check("taps_d1", {28'b0, taps1}, {28'b0, q1[0]});
`endif
  endtask

  initial begin
    logic [9:0] lat_in;
    logic [9:0] lat_out;
    logic [7:0] wv [3];
    lat_in  = 10'b1001111000;  // bit 9 = edge 2 ... bit 0 = edge 11
    lat_out = 10'b0100111100;  // out right after edges 2..11
    wv[0] = 8'hA5; wv[1] = 8'h3C; wv[2] = 8'hFF;
    reset = 1'b1; stall = 1'b0; flush = 1'b0; in2 = 1'b0; in3 = '0; in1 = '0;
    q2 = '{1'bx, 1'bx};
    q3 = '{8'hxx, 8'hxx, 8'hxx};
    q1 = '{4'hx};

    // Reset held for two edges with in high
    step(1, 0, 0, 1, 8'hFF, 4'hF);
    check("reset_out0", {31'b0, out2}, 32'd0);
    step(1, 0, 0, 1, 8'hFF, 4'hF);
    check("reset_out1", {31'b0, out2}, 32'd0);

    // Latency table for DEPTH=2 starting at edge 2
    for (int k = 0; k < 10; k++) begin
      step(0, 0, 0, lat_in[9-k], 8'(k), 4'(k));
      check("latency_d2", {31'b0, out2}, {31'b0, lat_out[9-k]});
    end

    // Mid-stream reset with ones in flight
    step(0, 0, 0, 1, 8'h77, 4'h7);
    step(0, 0, 0, 1, 8'h66, 4'h6);
    step(1, 0, 0, 1, 8'h55, 4'h5);
    check("midreset_d2", {31'b0, out2}, 32'd0);
    check("midreset_d3", {24'b0, out3}, 32'd0);

    // Stall: shift 1,0 then hold three edges with in=1, then resume
    step(0, 0, 0, 1, 8'h11, 4'h1);
    step(0, 0, 0, 0, 8'h22, 4'h2);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 1, 1, 8'hEE, 4'hE);
      check("stall_hold_d2", {31'b0, out2}, 32'd1);
    end
    step(0, 0, 0, 1, 8'h33, 4'h3);
    check("stall_resume_d2", {31'b0, out2}, 32'd0);
    step(0, 0, 0, 0, 8'h44, 4'h4);
    check("stall_resume2_d2", {31'b0, out2}, 32'd1);

    // Flush beats stall
    step(0, 0, 0, 1, 8'h99, 4'h9);
    step(0, 0, 0, 1, 8'h88, 4'h8);
    step(0, 1, 1, 1, 8'h77, 4'h7);
    check("flush_d2", {31'b0, out2}, 32'd0);
    check("flush_d1", {28'b0, out1}, 32'd0);

    // Wide/deep sweep: A5,3C,FF appear exactly three edges later
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0, wv[k], 4'(k));
    check("sweep_a5", {24'b0, out3}, 32'hA5);
    for (int k = 1; k < 3; k++) begin
      step(0, 0, 0, 0, 8'h00, 4'h0);
      check("sweep_seq", {24'b0, out3}, {24'b0, wv[k]});
    end

    // Randomised traffic with occasional stall/flush/reset
    for (int k = 0; k < 300; k++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 3) == 0), 1'($urandom), 8'($urandom), 4'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
